alu_issue_ctrl: RTL

- Sequencing front end that drives the combinational ALU's operand and select inputs; the ALU itself is the back end of this interface.
- Accepts one decoded-instruction beat per valid/ready handshake and maps opcode/funct to an alu_oper_type select and to operands, applying immediate extension per instruction.
- Registers the ALU result, computes a true full-width zero flag, and returns the result on a valid/ready response channel.
- Sits between the register-read stage and the ALU/writeback of the multicycle datapath.

---
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of a combinational ALU: decodes one instruction per
// handshake, drives registered ALU operands/select, and returns the captured result.
package alu_issue_pkg;
  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLTU = 3'd5,
    ALU_NOR  = 3'd6
  } alu_oper_type;

  typedef logic [31:0] bus_type;
endpackage

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic [15:0]      in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output alu_oper_type     alu_sel,
  input  logic [WIDTH-1:0] alu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_wb_en,
  output logic             out_illegal,
  output logic [1:0]       dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both
  // high; once raised, out_valid and all out_* hold steady until that transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic             accept;
  logic             dec_legal;
  logic             dec_wb;
  alu_oper_type     dec_sel;
  logic [WIDTH-1:0] dec_b;
  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] imm_zx;
  logic             wb_pend;

  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;
  assign imm_sx    = {{(WIDTH-16){in_imm[15]}}, in_imm};
  assign imm_zx    = {{(WIDTH-16){1'b0}}, in_imm};

  always_comb begin
    dec_legal = 1'b1;
    dec_wb    = 1'b1;
    dec_sel   = ALU_AND;
    dec_b     = in_rt_data;
    case (in_opcode)
      6'h00: begin
        case (in_funct)
          6'h24:        dec_sel = ALU_AND;
          6'h25:        dec_sel = ALU_OR;
          6'h20, 6'h21: dec_sel = ALU_ADD;
          6'h22, 6'h23: dec_sel = ALU_SUB;
          6'h2A:        dec_sel = ALU_SLT;
          6'h2B:        dec_sel = ALU_SLTU;
          6'h27:        dec_sel = ALU_NOR;
          default:      dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        dec_sel = ALU_ADD;
        dec_b   = imm_sx;
      end
      6'h0A: begin
        dec_sel = ALU_SLT;
        dec_b   = imm_sx;
      end
      // SLTIU sign-extends the immediate but compares unsigned.
      6'h0B: begin
        dec_sel = ALU_SLTU;
        dec_b   = imm_sx;
      end
      6'h0C: begin
        dec_sel = ALU_AND;
        dec_b   = imm_zx;
      end
      6'h0D: begin
        dec_sel = ALU_OR;
        dec_b   = imm_zx;
      end
      6'h04, 6'h05: begin
        dec_sel = ALU_SUB;
        dec_wb  = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = dec_legal ? EXEC : RESP;
      EXEC:    state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= ALU_AND;
      wb_pend     <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept && dec_legal) begin
            alu_a   <= in_rs_data;
            alu_b   <= dec_b;
            alu_sel <= dec_sel;
            wb_pend <= dec_wb;
          end else if (accept) begin
            // Illegal beats skip EXEC and leave the ALU operands untouched.
            out_valid   <= 1'b1;
            out_illegal <= 1'b1;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_wb_en   <= 1'b0;
          end
        end
        EXEC: begin
          out_valid   <= 1'b1;
          out_result  <= alu_s;
          out_zero    <= (alu_s == '0);
          out_wb_en   <= wb_pend;
          out_illegal <= 1'b0;
        end
        RESP: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
